// File: rtl/idex_pkg.sv
// Shared opcode/funct constants, ALU Signal codes, decode helper and FSM state type
// for the ID/EX issue stage.
package idex_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MULTU = 6'd25;

    localparam logic [5:0] SIG_ADD  = 6'd32;
    localparam logic [5:0] SIG_SUB  = 6'd34;
    localparam logic [5:0] SIG_AND  = 6'd36;
    localparam logic [5:0] SIG_OR   = 6'd37;
    localparam logic [5:0] SIG_SLT  = 6'd42;

    typedef enum logic [0:0] {
        StRun,
        StMultWait
    } state_e;

    typedef struct packed {
        logic [5:0] signal;
        logic       legal;
        logic       use_imm;
        logic       is_srl;
        logic       is_multu;
    } decode_t;

    function automatic decode_t idex_decode(input logic [5:0] opcode, input logic [5:0] funct);
        decode_t d;
        d.signal   = SIG_ADD;
        d.legal    = 1'b1;
        d.use_imm  = 1'b0;
        d.is_srl   = 1'b0;
        d.is_multu = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                d.signal   = funct;
                d.is_srl   = (funct == FN_SRL);
                d.is_multu = (funct == FN_MULTU);
            end
            OP_ADDI:      begin d.signal = SIG_ADD; d.use_imm = 1'b1; end
            OP_ANDI:      begin d.signal = SIG_AND; d.use_imm = 1'b1; end
            OP_ORI:       begin d.signal = SIG_OR;  d.use_imm = 1'b1; end
            OP_SLTI:      begin d.signal = SIG_SLT; d.use_imm = 1'b1; end
            OP_LW, OP_SW: begin d.signal = SIG_ADD; d.use_imm = 1'b1; end
            OP_BEQ:       d.signal = SIG_SUB;
            // Unknown opcodes run as a harmless ADD that never writes back.
            default:      d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/idex_fwd_mux.sv
// Combinational forward select for one source operand: EX/MEM, then MEM/WB, then register file.
// Forwarding is present only when IDEX_FWD_EN is defined; otherwise the register-file value passes.
module idex_fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_res,
    output logic [DATA_W-1:0] fwd_data
);

`ifdef IDEX_FWD_EN
    logic ex_hit;
    logic wb_hit;

    // r0 is hardwired, so a write aimed at it must never be forwarded.
    assign ex_hit = exmem_wr && (exmem_rd != '0) && (exmem_rd == src);
    assign wb_hit = memwb_wr && (memwb_rd != '0) && (memwb_rd == src);

    always_comb begin
        fwd_data = rf_data;
        if (ex_hit) begin
            fwd_data = exmem_res;
        end else if (wb_hit) begin
            fwd_data = memwb_res;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{src, exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res};
    assign fwd_data   = rf_data;
`endif

endmodule

// File: rtl/idex_issue_stage.sv
// ID/EX pipeline register and issue control feeding the ALU, with MULTU stall FSM.
// Optional operand forwarding is enabled by defining IDEX_FWD_EN.
module idex_issue_stage
    import idex_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned MULT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_res,
    input  logic              alu_multend,
    output logic              id_stall,
    output logic [DATA_W-1:0] alu_dataA,
    output logic [DATA_W-1:0] alu_dataB,
    output logic [5:0]        alu_signal,
    output logic [5:0]        alu_opcode,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              mult_err
);

    localparam int unsigned CNT_W = (MULT_TIMEOUT > 2) ? $clog2(MULT_TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] a_q, b_q;
    logic [5:0]        sig_q, opc_q;
    logic              ex_valid_q, ex_rw_q;
    logic [REG_AW-1:0] ex_rd_q;

    decode_t           dec;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [DATA_W-1:0] a_d, b_d;
    logic              capture;
    logic              load;

    assign dec     = idex_decode(id_opcode, id_funct);
    assign capture = id_valid && !id_stall;
    assign load    = capture && !flush;

    idex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src       (id_rs),
        .rf_data   (id_rs_data),
        .exmem_wr  (exmem_wr),
        .exmem_rd  (exmem_rd),
        .exmem_res (exmem_res),
        .memwb_wr  (memwb_wr),
        .memwb_rd  (memwb_rd),
        .memwb_res (memwb_res),
        .fwd_data  (rs_val)
    );

    idex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src       (id_rt),
        .rf_data   (id_rt_data),
        .exmem_wr  (exmem_wr),
        .exmem_rd  (exmem_rd),
        .exmem_res (exmem_res),
        .memwb_wr  (memwb_wr),
        .memwb_rd  (memwb_rd),
        .memwb_res (memwb_res),
        .fwd_data  (rt_val)
    );

    always_comb begin
        a_d = rs_val;
        b_d = rt_val;
        if (dec.is_srl) begin
            a_d = {{(DATA_W-5){1'b0}}, id_shamt};
        end else if (dec.use_imm) begin
            b_d = id_imm;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StRun: begin
                cnt_d = '0;
                if (load && dec.is_multu) begin
                    state_d = StMultWait;
                end
            end
            StMultWait: begin
                if (alu_multend) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MULT_TIMEOUT - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A flushed capture or an idle cycle leaves a bubble; ALU operands keep their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            sig_q      <= '0;
            opc_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_rw_q    <= 1'b0;
        end else if (load) begin
            a_q        <= a_d;
            b_q        <= b_d;
            sig_q      <= dec.signal;
            opc_q      <= id_opcode;
            ex_valid_q <= 1'b1;
            ex_rd_q    <= id_rd;
            ex_rw_q    <= id_reg_write && dec.legal && !dec.is_multu;
        end else begin
            ex_valid_q <= 1'b0;
            ex_rw_q    <= 1'b0;
        end
    end

    assign id_stall     = (state_q == StMultWait);
    assign alu_dataA    = a_q;
    assign alu_dataB    = b_q;
    assign alu_signal   = sig_q;
    assign alu_opcode   = opc_q;
    assign ex_valid     = ex_valid_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_rw_q;
    assign mult_err     = err_q;

endmodule

// File: tb/tb_idex_issue_stage.sv
// Directed self-checking bench for idex_issue_stage; forwarding expectations follow IDEX_FWD_EN.
module tb_idex_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write, flush;
    logic        exmem_wr, memwb_wr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_res, memwb_res;
    logic        alu_multend;
    logic        id_stall;
    logic [31:0] alu_dataA, alu_dataB;
    logic [5:0]  alu_signal, alu_opcode;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, mult_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    idex_issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_funct     (id_funct),
        .id_shamt     (id_shamt),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .flush        (flush),
        .exmem_wr     (exmem_wr),
        .exmem_rd     (exmem_rd),
        .exmem_res    (exmem_res),
        .memwb_wr     (memwb_wr),
        .memwb_rd     (memwb_rd),
        .memwb_res    (memwb_res),
        .alu_multend  (alu_multend),
        .id_stall     (id_stall),
        .alu_dataA    (alu_dataA),
        .alu_dataB    (alu_dataB),
        .alu_signal   (alu_signal),
        .alu_opcode   (alu_opcode),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .mult_err     (mult_err)
    );

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic rw);
        id_valid = 1'b1; id_opcode = op; id_funct = fn; id_shamt = sh;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_reg_write = rw;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); alu_multend = 1'b0;
        issue(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        id_valid = 1'b0;
        exmem_wr = 1'b0; exmem_rd = '0; exmem_res = '0;
        memwb_wr = 1'b0; memwb_rd = '0; memwb_res = '0;
        tick(); tick();
        n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0h want 0", id_stall); end
        n_checks++; if (alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0h/%0h want 0/0", alu_dataA, alu_dataB); end
        n_checks++; if (alu_signal !== 6'd0 || alu_opcode !== 6'd0) begin n_fail++; $display("FAIL reset_sig got %0d/%0d want 0/0", alu_signal, alu_opcode); end
        n_checks++; if ({ex_valid, ex_reg_write, ex_rd, mult_err} !== 8'd0) begin n_fail++; $display("FAIL reset_ex got %0h want 0", {ex_valid, ex_reg_write, ex_rd, mult_err}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        issue(6'd0, 6'd32, 5'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b1);
        tick();
        idle();
        n_checks++; if (alu_signal !== 6'd32) begin n_fail++; $display("FAIL add_signal got %0d want 32", alu_signal); end
        n_checks++; if (alu_dataA !== 32'd5 || alu_dataB !== 32'd7) begin n_fail++; $display("FAIL add_data got %0h/%0h want 5/7", alu_dataA, alu_dataB); end
        n_checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_rd !== 5'd3) begin n_fail++; $display("FAIL add_ex got v%0b w%0b rd%0d want v1 w1 rd3", ex_valid, ex_reg_write, ex_rd); end
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL idle_bubble got v%0b w%0b want 0 0", ex_valid, ex_reg_write); end
        n_checks++; if (alu_dataA !== 32'd5 || alu_signal !== 6'd32) begin n_fail++; $display("FAIL idle_hold got %0h/%0d want 5/32", alu_dataA, alu_signal); end
    endtask

    task automatic test_srl();
        issue(6'd0, 6'd2, 5'd4, 5'd6, 5'd7, 5'd8, 32'h123, 32'hF0, 32'd0, 1'b1);
        tick();
        idle();
        n_checks++; if (alu_dataA !== 32'd4 || alu_dataB !== 32'hF0) begin n_fail++; $display("FAIL srl_data got %0h/%0h want 4/f0", alu_dataA, alu_dataB); end
        n_checks++; if (alu_signal !== 6'd2) begin n_fail++; $display("FAIL srl_signal got %0d want 2", alu_signal); end
    endtask

    task automatic test_imm();
        issue(6'd13, 6'd0, 5'd0, 5'd4, 5'd5, 5'd5, 32'h11, 32'h99, 32'hFFFF_FF00, 1'b1);
        tick();
        n_checks++; if (alu_signal !== 6'd37 || alu_opcode !== 6'd13) begin n_fail++; $display("FAIL ori_sig got %0d/%0d want 37/13", alu_signal, alu_opcode); end
        n_checks++; if (alu_dataA !== 32'h11 || alu_dataB !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL ori_data got %0h/%0h want 11/ffffff00", alu_dataA, alu_dataB); end
        issue(6'd35, 6'd0, 5'd0, 5'd4, 5'd5, 5'd5, 32'h200, 32'h99, 32'h8, 1'b1);
        tick();
        n_checks++; if (alu_signal !== 6'd32 || alu_dataB !== 32'h8) begin n_fail++; $display("FAIL lw got %0d/%0h want 32/8", alu_signal, alu_dataB); end
        issue(6'd2, 6'd0, 5'd0, 5'd4, 5'd5, 5'd9, 32'h1, 32'h2, 32'h3, 1'b1);
        tick();
        n_checks++; if (alu_signal !== 6'd32 || ex_reg_write !== 1'b0 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL illegal got sig%0d w%0b v%0b want 32 0 1", alu_signal, ex_reg_write, ex_valid); end
        issue(6'd4, 6'd0, 5'd0, 5'd4, 5'd5, 5'd0, 32'hA, 32'hB, 32'h3, 1'b0);
        tick();
        idle();
        n_checks++; if (alu_signal !== 6'd34 || alu_dataB !== 32'hB) begin n_fail++; $display("FAIL beq got %0d/%0h want 34/b", alu_signal, alu_dataB); end
    endtask

    task automatic test_flush();
        issue(6'd0, 6'd32, 5'd0, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'd0, 1'b1);
        flush = 1'b1;
        tick();
        idle();
        n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL flush got v%0b w%0b want 0 0", ex_valid, ex_reg_write); end
    endtask

    task automatic test_fwd();
        logic [31:0] exp_a;
        exmem_wr = 1'b1; exmem_rd = 5'd1; exmem_res = 32'd9;
        memwb_wr = 1'b1; memwb_rd = 5'd1; memwb_res = 32'd4;
        issue(6'd0, 6'd32, 5'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b1);
        tick();
`ifdef IDEX_FWD_EN
        exp_a = 32'd9;
`else
        exp_a = 32'd5;
`endif
        n_checks++; if (alu_dataA !== exp_a || alu_dataB !== 32'd7) begin n_fail++; $display("FAIL fwd_exmem got %0h/%0h want %0h/7", alu_dataA, alu_dataB, exp_a); end
        exmem_rd = 5'd0;
        tick();
`ifdef IDEX_FWD_EN
        exp_a = 32'd4;
`else
        exp_a = 32'd5;
`endif
        n_checks++; if (alu_dataA !== exp_a) begin n_fail++; $display("FAIL fwd_exmem_r0 got %0h want %0h", alu_dataA, exp_a); end
        memwb_wr = 1'b0;
        tick();
        n_checks++; if (alu_dataA !== 32'd5) begin n_fail++; $display("FAIL fwd_none got %0h want 5", alu_dataA); end
        exmem_rd = 5'd2; memwb_wr = 1'b1; memwb_rd = 5'd0;
        issue(6'd0, 6'd32, 5'd0, 5'd0, 5'd2, 5'd3, 32'd0, 32'd7, 32'd0, 1'b1);
        tick();
        idle();
`ifdef IDEX_FWD_EN
        exp_a = 32'd9;
`else
        exp_a = 32'd7;
`endif
        n_checks++; if (alu_dataA !== 32'd0 || alu_dataB !== exp_a) begin n_fail++; $display("FAIL fwd_rs0 got %0h/%0h want 0/%0h", alu_dataA, alu_dataB, exp_a); end
        exmem_wr = 1'b0; exmem_rd = '0; exmem_res = '0;
        memwb_wr = 1'b0; memwb_rd = '0; memwb_res = '0;
    endtask

    task automatic test_multu();
        int n_stall;
        int n_bad;
        issue(6'd0, 6'd25, 5'd0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd6, 32'd0, 1'b0);
        tick();
        n_checks++; if (id_stall !== 1'b1 || ex_valid !== 1'b1 || ex_reg_write !== 1'b0 || alu_signal !== 6'd25) begin n_fail++; $display("FAIL multu_issue got s%0b v%0b w%0b sig%0d want 1 1 0 25", id_stall, ex_valid, ex_reg_write, alu_signal); end
        issue(6'd0, 6'd32, 5'd0, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'd0, 1'b1);
        n_stall = 0;
        n_bad   = 0;
        for (int k = 0; k < 32; k++) begin
            if (id_stall) n_stall++;
            if (alu_dataA !== 32'd3 || alu_dataB !== 32'd6 || alu_signal !== 6'd25 || alu_opcode !== 6'd0) n_bad++;
            if (k > 0 && ex_valid !== 1'b0) n_bad++;
            flush       = (k == 10);
            alu_multend = (k == 31);
            tick();
            alu_multend = 1'b0;
            flush       = 1'b0;
        end
        n_checks++; if (n_stall !== 32) begin n_fail++; $display("FAIL multu_stall_len got %0d want 32", n_stall); end
        n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL multu_frozen got %0d bad cycles want 0", n_bad); end
        n_checks++; if (id_stall !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL multu_release got s%0b v%0b want 0 0", id_stall, ex_valid); end
        tick();
        idle();
        n_checks++; if (ex_valid !== 1'b1 || alu_signal !== 6'd32 || alu_dataA !== 32'hA || alu_dataB !== 32'hB) begin n_fail++; $display("FAIL multu_queued got v%0b sig%0d %0h/%0h want 1 32 a/b", ex_valid, alu_signal, alu_dataA, alu_dataB); end
        n_checks++; if (mult_err !== 1'b0) begin n_fail++; $display("FAIL multu_err got %0b want 0", mult_err); end
    endtask

    task automatic test_timeout();
        int n_stall;
        issue(6'd0, 6'd25, 5'd0, 5'd1, 5'd2, 5'd0, 32'd8, 32'd9, 32'd0, 1'b0);
        tick();
        idle();
        n_stall = 0;
        for (int k = 0; k < 100; k++) begin
            if (!id_stall) break;
            n_stall++;
            tick();
        end
        n_checks++; if (n_stall !== 64) begin n_fail++; $display("FAIL timeout_len got %0d want 64", n_stall); end
        n_checks++; if (mult_err !== 1'b1 || id_stall !== 1'b0) begin n_fail++; $display("FAIL timeout_err got e%0b s%0b want 1 0", mult_err, id_stall); end
        alu_multend = 1'b1;
        tick();
        alu_multend = 1'b0;
        tick();
        n_checks++; if (mult_err !== 1'b1 || id_stall !== 1'b0) begin n_fail++; $display("FAIL run_multend got e%0b s%0b want 1 0", mult_err, id_stall); end
    endtask

    task automatic test_reset_mid();
        issue(6'd0, 6'd25, 5'd0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd6, 32'd0, 1'b0);
        tick();
        idle();
        repeat (5) tick();
        n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL mid_stall got %0b want 1", id_stall); end
        #3 reset = 1'b1;
        #1;
        n_checks++; if (id_stall !== 1'b0 || mult_err !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl got s%0b e%0b v%0b want 0 0 0", id_stall, mult_err, ex_valid); end
        n_checks++; if (alu_dataA !== 32'd0 || alu_dataB !== 32'd0 || alu_signal !== 6'd0) begin n_fail++; $display("FAIL async_reset_data got %0h/%0h/%0d want 0/0/0", alu_dataA, alu_dataB, alu_signal); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall got %0b want 0", id_stall); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_srl();
        test_imm();
        test_flush();
        test_fwd();
        test_multu();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
